// File: rtl/pc_next_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_next_unit_if
//  Purpose  : Issue -> next-PC -> IF handshake bundle for pc_next_unit.
//             Signal names keep the unit's point of view (_i into the unit,
//             _o out of the unit).
//  Modports : master - environment side (Issue/IF), drives the unit inputs
//             slave  - pc_next_unit itself
//  Revision : 1.0 - initial release
// ============================================================================
interface pc_next_unit_if #(
    parameter int XLEN = 32
);
    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [1:0]      mode_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] imm_i;
    logic            ilen2_i;
    logic            cmp_i;
    logic            rd_link_i;
    logic            rs1_link_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] pc_next_o;
    logic [XLEN-1:0] link_o;
    logic            misaligned_o;
    logic [XLEN-1:0] ras_top_o;
    logic            ras_valid_o;

    modport master (
        output flush_i, in_valid_i, mode_i, pc_i, rs1_i, imm_i, ilen2_i,
               cmp_i, rd_link_i, rs1_link_i, out_ready_i,
        input  in_ready_o, out_valid_o, pc_next_o, link_o, misaligned_o,
               ras_top_o, ras_valid_o
    );

    modport slave (
        input  flush_i, in_valid_i, mode_i, pc_i, rs1_i, imm_i, ilen2_i,
               cmp_i, rd_link_i, rs1_link_i, out_ready_i,
        output in_ready_o, out_valid_o, pc_next_o, link_o, misaligned_o,
               ras_top_o, ras_valid_o
    );
endinterface
`default_nettype wire

// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_next_unit
//  Purpose  : Registered next-PC generator between Issue and IF. Resolves
//             SEQ / BRANCH / JAL / JALR targets, flags misaligned targets and
//             keeps a small circular return-address stack as a hint for IF.
//  Ports    : clk_i  - clock, rising edge
//             rst_ni - asynchronous active-low reset
//             bus    - pc_next_unit_if.slave (input op, output register,
//                      valid/ready on both sides, flush, RAS view)
//  Revision : 1.0 - initial release
// ============================================================================
module pc_next_unit #(
    parameter int          XLEN       = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0080,
    parameter bit          COMPRESSED = 1'b1,
    parameter int          RAS_DEPTH  = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    pc_next_unit_if.slave bus
);
    localparam logic [1:0]      MODE_SEQ  = 2'b00;
    localparam logic [1:0]      MODE_BR   = 2'b01;
    localparam logic [1:0]      MODE_JAL  = 2'b10;
    localparam logic [1:0]      MODE_JALR = 2'b11;
    localparam int              PW        = $clog2(RAS_DEPTH);
    localparam int              CW        = PW + 1;
    localparam logic [XLEN-1:0] RESET_VAL = XLEN'(RESET_PC);

    // ---------------- target computation ----------------
    logic [XLEN-1:0] ilen;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] target;
    logic            redirect;     // target came from an offset/register
    logic            misaligned;

    assign ilen = (COMPRESSED && bus.ilen2_i) ? XLEN'(2) : XLEN'(4);
    assign link = bus.pc_i + ilen;

    always_comb begin
        target   = link;
        redirect = 1'b0;
        case (bus.mode_i)
            MODE_SEQ: begin
                target   = link;
                redirect = 1'b0;
            end
            MODE_BR: begin
                target   = bus.cmp_i ? (bus.pc_i + bus.imm_i) : link;
                redirect = bus.cmp_i;
            end
            MODE_JAL: begin
                target   = bus.pc_i + bus.imm_i;
                redirect = 1'b1;
            end
            MODE_JALR: begin
                target   = (bus.rs1_i + bus.imm_i) & ~XLEN'(1);
                redirect = 1'b1;
            end
            default: begin
                target   = link;
                redirect = 1'b0;
            end
        endcase
    end

    // Fall-through addresses are never flagged, even if pc_i itself is odd.
    assign misaligned = redirect & (target[0] | (!COMPRESSED & target[1]));

    // ---------------- handshake / output register ----------------
    logic            out_valid_q;
    logic [XLEN-1:0] pc_next_q;
    logic [XLEN-1:0] link_q;
    logic            misaligned_q;
    logic            in_ready;
    logic            accept;
    logic            update;

    assign in_ready = ~out_valid_q | bus.out_ready_i;
    assign accept   = bus.in_valid_i & in_ready;
    assign update   = accept & ~bus.flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            pc_next_q    <= RESET_VAL;
            link_q       <= '0;
            misaligned_q <= 1'b0;
        end else if (bus.flush_i) begin
            out_valid_q  <= 1'b0;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            pc_next_q    <= target;
            link_q       <= link;
            misaligned_q <= misaligned;
        end else if (bus.out_ready_i) begin
            out_valid_q  <= 1'b0;
        end
    end

    // ---------------- return-address stack ----------------
    // ras_ptr always indexes the current top; a push pre-increments so a
    // full stack silently overwrites its oldest entry.
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr, ptr_nx, ptr_m1, wr_idx;
    logic [CW-1:0]   ras_cnt, cnt_nx;
    logic [XLEN-1:0] ras_top_q, top_nx;
    logic            wr_en;
    logic            is_jal_any, push, pop, replace;

    assign is_jal_any = (bus.mode_i == MODE_JAL) | (bus.mode_i == MODE_JALR);
    assign push       = update & is_jal_any & bus.rd_link_i;
    assign pop        = update & (bus.mode_i == MODE_JALR) & bus.rs1_link_i & ~bus.rd_link_i;
    assign replace    = push & (bus.mode_i == MODE_JALR) & bus.rs1_link_i;
    assign ptr_m1     = ras_ptr - 1'b1;

    always_comb begin
        ptr_nx = ras_ptr;
        cnt_nx = ras_cnt;
        top_nx = ras_top_q;
        wr_en  = 1'b0;
        wr_idx = ras_ptr;
        if (bus.flush_i) begin
            cnt_nx = '0;
            top_nx = '0;
        end else if (replace && (ras_cnt != '0)) begin
            // pop-then-push on a non-empty stack rewrites the top in place
            wr_en  = 1'b1;
            top_nx = link;
        end else if (push) begin
            ptr_nx = ras_ptr + 1'b1;
            wr_idx = ras_ptr + 1'b1;
            wr_en  = 1'b1;
            cnt_nx = (ras_cnt == CW'(RAS_DEPTH)) ? ras_cnt : ras_cnt + 1'b1;
            top_nx = link;
        end else if (pop && (ras_cnt != '0)) begin
            ptr_nx = ptr_m1;
            cnt_nx = ras_cnt - 1'b1;
            top_nx = (ras_cnt > CW'(1)) ? ras_mem[ptr_m1] : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ras_ptr   <= '0;
            ras_cnt   <= '0;
            ras_top_q <= '0;
        end else begin
            ras_ptr   <= ptr_nx;
            ras_cnt   <= cnt_nx;
            ras_top_q <= top_nx;
        end
    end

    // Storage needs no reset: entries are only read below the valid count.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            ras_mem[wr_idx] <= link;
        end
    end

    // ---------------- outputs ----------------
    assign bus.in_ready_o   = in_ready;
    assign bus.out_valid_o  = out_valid_q;
    assign bus.pc_next_o    = pc_next_q;
    assign bus.link_o       = link_q;
    assign bus.misaligned_o = misaligned_q;
    assign bus.ras_top_o    = ras_top_q;
    assign bus.ras_valid_o  = (ras_cnt != '0);
endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_next_unit
//  Purpose  : Self-checking bench. Two units (COMPRESSED=1 and =0) receive
//             identical stimulus; a reference model pushes expected outputs
//             into per-unit scoreboards that a monitor pops on consumption.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_next_unit;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] lnk;
        logic        mis;
        logic [31:0] top;
        logic        rv;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        flush = 0, in_valid = 0, ilen2 = 0, cmp = 0, rd_link = 0, rs1_link = 0;
    logic        out_ready = 1, rand_rdy = 0;
    logic [1:0]  mode = 0;
    logic [31:0] pc = 0, rs1 = 0, imm = 0;

    int checks = 0;
    int failures = 0;

    exp_t        sb    [2][$];   // [0] compressed unit, [1] non-compressed unit
    logic [31:0] ras_m [2][$];

    pc_next_unit_if #(.XLEN(XLEN)) bus_c ();
    pc_next_unit_if #(.XLEN(XLEN)) bus_n ();

    always_comb begin
        bus_c.flush_i = flush;     bus_n.flush_i = flush;
        bus_c.in_valid_i = in_valid; bus_n.in_valid_i = in_valid;
        bus_c.mode_i = mode;       bus_n.mode_i = mode;
        bus_c.pc_i = pc;           bus_n.pc_i = pc;
        bus_c.rs1_i = rs1;         bus_n.rs1_i = rs1;
        bus_c.imm_i = imm;         bus_n.imm_i = imm;
        bus_c.ilen2_i = ilen2;     bus_n.ilen2_i = ilen2;
        bus_c.cmp_i = cmp;         bus_n.cmp_i = cmp;
        bus_c.rd_link_i = rd_link; bus_n.rd_link_i = rd_link;
        bus_c.rs1_link_i = rs1_link; bus_n.rs1_link_i = rs1_link;
        bus_c.out_ready_i = out_ready; bus_n.out_ready_i = out_ready;
    end

    pc_next_unit #(.XLEN(XLEN), .RESET_PC(32'h80), .COMPRESSED(1'b1), .RAS_DEPTH(4))
        dut_c (.clk_i(clk), .rst_ni(rst_n), .bus(bus_c));
    pc_next_unit #(.XLEN(XLEN), .RESET_PC(32'h80), .COMPRESSED(1'b0), .RAS_DEPTH(4))
        dut_n (.clk_i(clk), .rst_ni(rst_n), .bus(bus_n));

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endfunction

    // Reference model: plain arithmetic plus a list-based stack.
    task automatic model(input int k, input logic [1:0] m, input logic [31:0] p, r, i,
                         input logic il2, c, rdl, rsl);
        exp_t        e;
        logic [31:0] len, lnk, tgt;
        logic        jump;
        len = (k == 0 && il2) ? 32'd2 : 32'd4;
        lnk = p + len;
        case (m)
            2'd0:    begin tgt = lnk; jump = 0; end
            2'd1:    begin tgt = c ? p + i : lnk; jump = c; end
            2'd2:    begin tgt = p + i; jump = 1; end
            default: begin tgt = (r + i) & 32'hFFFF_FFFE; jump = 1; end
        endcase
        e.pc  = tgt;
        e.lnk = lnk;
        e.mis = jump && (tgt[0] || (k == 1 && tgt[1]));
        if (m == 2'd3 && rsl && ras_m[k].size() > 0) void'(ras_m[k].pop_back());
        if (m >= 2'd2 && rdl) begin
            ras_m[k].push_back(lnk);
            if (ras_m[k].size() > 4) void'(ras_m[k].pop_front());
        end
        e.rv  = (ras_m[k].size() != 0);
        e.top = e.rv ? ras_m[k][ras_m[k].size()-1] : 32'd0;
        sb[k].push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [1:0] m, input logic [31:0] p, r, i,
                         input logic il2, c, rdl, rsl, fl);
        logic acc = 0;
        mode = m; pc = p; rs1 = r; imm = i; ilen2 = il2; cmp = c;
        rd_link = rdl; rs1_link = rsl; flush = fl; in_valid = 1;
        for (int n = 0; n < 64 && !acc; n++) begin
            #7;
            if (fl) begin
                for (int k = 0; k < 2; k++) begin sb[k].delete(); ras_m[k].delete(); end
                acc = 1;
            end else if (bus_c.in_ready_o) begin
                model(0, m, p, r, i, il2, c, rdl, rsl);
                model(1, m, p, r, i, il2, c, rdl, rsl);
                acc = 1;
            end
            @(posedge clk); #1;
        end
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
        in_valid = 0; flush = 0;
    endtask

    task automatic idle();
        in_valid = 0;
        @(posedge clk); #1;
    endtask

    task automatic mon(input int k, input logic ov, rdy, input logic [31:0] p, l,
                       input logic ms, input logic [31:0] t, input logic rv);
        string u;
        u = (k == 0) ? "c" : "n";
        if (ov) begin
            if (sb[k].size() == 0) begin
                chk({"unexpected_out_", u}, 32'(ov), 32'd0);
            end else begin
                chk({"pc_next_", u}, p, sb[k][0].pc);
                chk({"link_", u}, l, sb[k][0].lnk);
                chk({"misaligned_", u}, 32'(ms), 32'(sb[k][0].mis));
                chk({"ras_top_", u}, t, sb[k][0].top);
                chk({"ras_valid_", u}, 32'(rv), 32'(sb[k][0].rv));
                if (rdy) void'(sb[k].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, bus_c.out_valid_o, out_ready, bus_c.pc_next_o, bus_c.link_o,
                bus_c.misaligned_o, bus_c.ras_top_o, bus_c.ras_valid_o);
            mon(1, bus_n.out_valid_o, out_ready, bus_n.pc_next_o, bus_n.link_o,
                bus_n.misaligned_o, bus_n.ras_top_o, bus_n.ras_valid_o);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Direct spot checks of the visible outputs right after an accept.
    task automatic expect_pc(string nm, logic [31:0] pc_c, pc_n, logic mis_c, mis_n);
        chk({nm, "_pc_c"}, bus_c.pc_next_o, pc_c);
        chk({nm, "_pc_n"}, bus_n.pc_next_o, pc_n);
        chk({nm, "_mis_c"}, 32'(bus_c.misaligned_o), 32'(mis_c));
        chk({nm, "_mis_n"}, 32'(bus_n.misaligned_o), 32'(mis_n));
    endtask

    task automatic expect_ras(string nm, logic [31:0] top, logic rv);
        chk({nm, "_top"}, bus_c.ras_top_o, top);
        chk({nm, "_valid"}, 32'(bus_c.ras_valid_o), 32'(rv));
    endtask

    logic [1:0]  r_m;
    logic [31:0] r_p, r_r, r_i;
    logic        r_il2, r_c, r_rdl, r_rsl, r_fl;

    initial begin
        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        chk("rst_pc_next", bus_c.pc_next_o, 32'h80);
        chk("rst_out_valid", 32'(bus_c.out_valid_o), 32'd0);
        chk("rst_ras_valid", 32'(bus_c.ras_valid_o), 32'd0);
        chk("rst_ras_top", bus_c.ras_top_o, 32'd0);
        chk("rst_link", bus_c.link_o, 32'd0);
        chk("rst_pc_next_n", bus_n.pc_next_o, 32'h80);
        rst_n = 1;
        @(posedge clk); #1;

        // ---------------- directed target cases ----------------
        issue(2'd0, 32'h80, 0, 0, 0, 0, 0, 0, 0);
        expect_pc("seq", 32'h84, 32'h84, 0, 0);
        chk("seq_link", bus_c.link_o, 32'h84);
        issue(2'd1, 32'h100, 0, 32'hFFFF_FFF0, 0, 1, 0, 0, 0);
        expect_pc("br_taken", 32'hF0, 32'hF0, 0, 0);
        issue(2'd1, 32'h100, 0, 32'hFFFF_FFF0, 1, 0, 0, 0, 0);
        expect_pc("br_nt_il2", 32'h102, 32'h104, 0, 0);
        issue(2'd3, 32'h0, 32'h2001, 32'h2, 0, 0, 0, 0, 0);
        expect_pc("jalr", 32'h2002, 32'h2002, 0, 1);
        issue(2'd2, 32'h10, 0, 32'h3, 0, 0, 0, 0, 0);
        expect_pc("jal_odd", 32'h13, 32'h13, 1, 1);
        issue(2'd0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);
        expect_pc("wrap", 32'h0, 32'h0, 0, 0);
        idle(); idle();

        // ---------------- backpressure ----------------
        out_ready = 0;
        issue(2'd2, 32'h400, 0, 32'h40, 0, 0, 0, 0, 0);
        fork
            issue(2'd0, 32'h500, 0, 0, 0, 0, 0, 0, 0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(bus_c.in_ready_o), 32'd0);
                    chk("stall_pc_hold", bus_c.pc_next_o, 32'h440);
                end
                @(posedge clk); #1;
                out_ready = 1;
            end
        join
        for (int n = 0; n < 4; n++) issue(2'd0, 32'h600 + 32'(n * 4), 0, 0, 0, 0, 0, 0, 0);
        idle(); idle();

        // ---------------- RAS fill, overwrite and drain ----------------
        for (int n = 0; n < 5; n++) issue(2'd2, 32'(n * 16), 0, 32'h100, 0, 0, 1, 0, 0);
        expect_ras("ras_full", 32'h44, 1);
        issue(2'd3, 0, 32'h200, 0, 0, 0, 0, 1, 0);
        expect_ras("ras_pop1", 32'h34, 1);
        issue(2'd3, 0, 32'h200, 0, 0, 0, 0, 1, 0);
        expect_ras("ras_pop2", 32'h24, 1);
        issue(2'd3, 0, 32'h200, 0, 0, 0, 0, 1, 0);
        expect_ras("ras_pop3", 32'h14, 1);
        issue(2'd3, 0, 32'h200, 0, 0, 0, 0, 1, 0);
        expect_ras("ras_pop4", 32'h0, 0);
        issue(2'd3, 0, 32'h200, 0, 0, 0, 0, 1, 0);
        expect_ras("ras_pop_empty", 32'h0, 0);

        // ---------------- flush against an accepted push ----------------
        issue(2'd2, 32'h700, 0, 32'h8, 0, 0, 1, 0, 0);
        issue(2'd2, 32'h800, 0, 32'h8, 0, 0, 1, 0, 1);
        chk("flush_out_valid", 32'(bus_c.out_valid_o), 32'd0);
        chk("flush_ras_valid", 32'(bus_c.ras_valid_o), 32'd0);
        idle();

        // ---------------- randomized traffic ----------------
        rand_rdy = 1;
        for (int n = 0; n < 400; n++) begin
            r_m   = 2'($urandom_range(0, 3));
            r_p   = $urandom() & 32'hFFFF_FFFE;
            r_r   = $urandom();
            r_i   = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 64)) - 32'd32;
            r_il2 = ($urandom_range(0, 1) == 1);
            r_c   = ($urandom_range(0, 1) == 1);
            r_rdl = ($urandom_range(0, 2) == 0);
            r_rsl = ($urandom_range(0, 2) == 0);
            r_fl  = ($urandom_range(0, 30) == 0);
            issue(r_m, r_p, r_r, r_i, r_il2, r_c, r_rdl, r_rsl, r_fl);
            if ($urandom_range(0, 3) == 0) idle();
        end

        // ---------------- drain ----------------
        rand_rdy = 0;
        out_ready = 1;
        for (int n = 0; n < 20 && (sb[0].size() != 0 || sb[1].size() != 0); n++) idle();
        chk("drain_c", 32'(sb[0].size()), 32'd0);
        chk("drain_n", 32'(sb[1].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
Registered next-PC generator between Issue and IF, parametrised in data width, reset vector, compressed-instruction support and return-address-stack depth. It resolves sequential, conditional-branch, JAL and JALR targets from Issue operands and the ALU comparison bit. It flags target misalignment and maintains a small return-address stack (RAS) that IF uses as a prediction hint. Issue and IF connect through valid/ready handshakes with a one-entry output register.

Parameters:
XLEN, 32, datapath and PC width
RESET_PC, 32'h0000_0080, pc_next_o value after reset; truncated/zero-extended to XLEN
COMPRESSED, 1, 1 = 2-byte alignment legal and 2-byte instruction lengths allowed; 0 = 4-byte alignment only
RAS_DEPTH, 4, RAS entries, power of two, 2..16

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  drop the pending output and empty the RAS
in_valid_i  in  1  Issue presents an operation
in_ready_o  out  1  unit accepts this cycle
mode_i  in  2  00 SEQ, 01 BRANCH, 10 JAL, 11 JALR
pc_i  in  XLEN  PC of the current instruction
rs1_i  in  XLEN  JALR base register
imm_i  in  XLEN  sign-extended offset
ilen2_i  in  1  instruction is 2 bytes; ignored (treated as 0) when COMPRESSED=0
cmp_i  in  1  ALU comparison result, 1 = branch taken
rd_link_i  in  1  rd is x1 or x5
rs1_link_i  in  1  rs1 is x1 or x5
out_valid_o  out  1  pc_next_o is valid
out_ready_i  in  1  IF consumes the output
pc_next_o  out  XLEN  next PC
link_o  out  XLEN  pc_i + instruction length, for rd writeback
misaligned_o  out  1  target violates alignment
ras_top_o  out  XLEN  top RAS entry
ras_valid_o  out  1  RAS non-empty

Behaviour:
- Reset (async, rst_ni=0):
  - out_valid_o=0, pc_next_o=RESET_PC, link_o=0, misaligned_o=0.
  - RAS pointer and count = 0; ras_valid_o=0; ras_top_o=0.
- Handshake:
  - in_ready_o = ~out_valid_o | out_ready_i (combinational).
  - Accept when in_valid_i & in_ready_o.
  - Outputs register on the accepting edge; latency 1 cycle.
  - Output holds stable while out_valid_o & ~out_ready_i.
  - Consume without a new accept: out_valid_o falls next cycle; pc_next_o keeps its last value.
  - Consume and accept in the same cycle: back-to-back, 1 operation per cycle.
- Instruction length: ilen = 2 if (COMPRESSED & ilen2_i), else 4. link = pc_i + ilen.
- Target computation (all sums modulo 2^XLEN, wrap silently):
  - SEQ: link.
  - BRANCH: cmp_i ? pc_i+imm_i : link.
  - JAL: pc_i+imm_i.
  - JALR: (rs1_i+imm_i) with bit0 forced to 0.
- misaligned_o is registered with the target:
  - set if target[0]=1 (BRANCH taken, or JAL), or if COMPRESSED=0 and target[1]=1.
  - Never set for SEQ or for a not-taken branch.
  - pc_next_o still carries the computed target when misaligned_o=1.
- RAS updates on accept only, and only when flush_i=0:
  - push link when mode is JAL or JALR and rd_link_i=1.
  - pop when mode is JALR, rs1_link_i=1 and rd_link_i=0.
  - JALR with rd_link_i=1, rs1_link_i=1 and rs1==rd is a push; with rs1!=rd it is pop-then-push (replace top). The unit uses rd_link_i & rs1_link_i as replace-top; Issue drives rs1_link_i=0 when rs1==rd.
  - Push when full: circular overwrite of the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty: no change, no error.
  - ras_top_o and ras_valid_o are registered; they reflect the update from the previous accept.
- flush_i (synchronous):
  - next cycle: out_valid_o=0 and RAS count=0.
  - Overrides a simultaneous accept; that operation is dropped.
  - in_ready_o is unaffected by flush_i.
- Reset mid-transaction: all state clears immediately and the pending output is lost.

Test Plan:
- Reset with RESET_PC=0x80 -> pc_next_o=0x80, out_valid_o=0, ras_valid_o=0; SEQ pc=0x80, ilen2=0 -> next cycle pc_next_o=0x84, link_o=0x84.
- BRANCH pc=0x100, imm=0xFFFFFFF0: cmp=1 -> 0xF0; cmp=0, ilen2=1, COMPRESSED=1 -> 0x102; COMPRESSED=0, ilen2=1 -> 0x104.
- JALR rs1=0x2001, imm=0x2 -> 0x2002, misaligned_o=0 when COMPRESSED=1 and 1 when COMPRESSED=0; JAL pc=0x10, imm=0x3 -> 0x13, misaligned_o=1.
- Backpressure: hold out_ready_i=0 for 3 cycles with in_valid_i=1 -> in_ready_o=0, outputs stable; release -> one operation per cycle, none lost or duplicated.
- RAS, RAS_DEPTH=4: five JAL with rd_link=1 at pc 0x0,0x10,0x20,0x30,0x40 (link +4) -> ras_top_o=0x44; four pops -> tops 0x34,0x24,0x14, then empty; a fifth pop -> no change.
- flush_i asserted together with an accepted JAL push -> out_valid_o=0 and ras_valid_o=0 next cycle; wrap case: pc=0xFFFFFFFC SEQ -> pc_next_o=0x0.
